next_serial_receiver: RTL and testbench



---
 rtl/next_link_pkg.sv | 35 +++
 rtl/next_serial_receiver_if.sv | 33 +++
 rtl/next_rx_outreg.sv | 44 ++++
 rtl/next_serial_receiver.sv | 138 +++++++++++++
 tb/tb_next_serial_receiver.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/next_link_pkg.sv
// Shared definitions for the NeXT ASIC single-wire serial link: packet geometry,
// reserved control payloads and the link FSM state encoding used by TX and RX.
package next_link_pkg;

    localparam int PKT_BITS = 41;
    localparam int DATA_W   = 40;

    localparam logic [DATA_W-1:0] PKT_AUDIO_REQ      = 40'h07_0000_0000;
    localparam logic [DATA_W-1:0] PKT_AUDIO_UNDERRUN = 40'h0F_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GUARD = 2'd2
    } link_state_t;

    typedef enum logic [1:0] {
        PK_DATA           = 2'd0,
        PK_AUDIO_REQ      = 2'd1,
        PK_AUDIO_UNDERRUN = 2'd2
    } pkt_kind_t;

    // An all-zero payload is data: the transmitter never frames zero as control.
    function automatic pkt_kind_t classify_pkt(input logic [DATA_W-1:0] p);
        pkt_kind_t kind;
        kind = PK_DATA;
        if (p == PKT_AUDIO_REQ) begin
            kind = PK_AUDIO_REQ;
        end else if (p == PKT_AUDIO_UNDERRUN) begin
            kind = PK_AUDIO_UNDERRUN;
        end
        return kind;
    endfunction

endpackage

// File: rtl/next_serial_receiver_if.sv
// Receiver-side output bundle: data valid/ready handshake plus event pulses.
interface next_serial_receiver_if;
    import next_link_pkg::*;

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              audio_req;
    logic              audio_underrun;
    logic              data_loss;
    logic              frame_error;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready,
        output audio_req,
        output audio_underrun,
        output data_loss,
        output frame_error
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready,
        input  audio_req,
        input  audio_underrun,
        input  data_loss,
        input  frame_error
    );

endinterface

// File: rtl/next_rx_outreg.sv
// One-entry valid/ready holding register for received data packets; a packet
// arriving while the entry is full and not being drained is dropped with a pulse.
module next_rx_outreg
    import next_link_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_data_loss
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_data_loss;
    logic              w_free;

    // Entry can take a new word if empty or being drained on this same edge.
    assign w_free = !r_valid || i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_data_loss <= 1'b0;
        end else begin
            r_data_loss <= i_load && !w_free;
            if (i_load && w_free) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_data_loss = r_data_loss;

endmodule

// File: rtl/next_serial_receiver.sv
// NeXT serial link receiver: start-bit detect, 40-bit deserialiser, packet classify.
// Optional macro RX_FRAME_CHECK_EN enforces GUARD_BITS idle zeros after each packet.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | line idle, waiting for a start bit (sin=1)
// ST_SHIFT | shifting in payload bits, counter 0..DATA_W-1
// ST_GUARD | post-packet gap; zero-length, or GUARD_BITS zeros with frame check
module next_serial_receiver #(
    parameter int GUARD_BITS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sin,
    next_serial_receiver_if.master rx
);
    import next_link_pkg::*;

    localparam int CNT_W = $clog2(DATA_W + GUARD_BITS + 1);

    link_state_t       r_state;
    link_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_pkt;
    pkt_kind_t         w_kind;
    logic              w_done;
    logic              r_audio_req;
    logic              r_audio_underrun;

`ifdef RX_FRAME_CHECK_EN
    logic              w_frame_error;
    logic              r_frame_error;
`endif

    assign w_pkt  = {r_shift[DATA_W-2:0], sin};
    assign w_kind = classify_pkt(w_pkt);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
`ifdef RX_FRAME_CHECK_EN
        w_frame_error = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (sin) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_GUARD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_GUARD: begin
`ifdef RX_FRAME_CHECK_EN
                // A high bit in the gap restarts the run of required zeros.
                if (sin) begin
                    w_frame_error = 1'b1;
                    w_cnt_nxt     = '0;
                end else if (r_cnt == CNT_W'(GUARD_BITS - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`else
                // Back-to-back packets: a high bit here is already the next start.
                if (sin) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
                w_cnt_nxt = '0;
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_shift          <= '0;
            r_audio_req      <= 1'b0;
            r_audio_underrun <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            if (r_state == ST_SHIFT) begin
                r_shift <= w_pkt;
            end
            r_audio_req      <= w_done && (w_kind == PK_AUDIO_REQ);
            r_audio_underrun <= w_done && (w_kind == PK_AUDIO_UNDERRUN);
        end
    end

`ifdef RX_FRAME_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= w_frame_error;
        end
    end

    assign rx.frame_error = r_frame_error;
`else
    assign rx.frame_error = 1'b0;
`endif

    next_rx_outreg u_outreg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_done && (w_kind == PK_DATA)),
        .i_data      (w_pkt),
        .i_ready     (rx.out_ready),
        .o_data      (rx.out_data),
        .o_valid     (rx.out_valid),
        .o_data_loss (rx.data_loss)
    );

    assign rx.audio_req      = r_audio_req;
    assign rx.audio_underrun = r_audio_underrun;

endmodule

// File: tb/tb_next_serial_receiver.sv
// Directed bench for next_serial_receiver: expected data words are queued as packets
// are sent and popped by a monitor on each valid/ready transfer.
module tb_next_serial_receiver;
    import next_link_pkg::*;

    logic clk;
    logic rst_n;
    logic sin;

    int checks   = 0;
    int failures = 0;
    int n_req    = 0;
    int n_und    = 0;
    int n_loss   = 0;
    int n_ferr   = 0;

    logic [DATA_W-1:0] exp_q[$];

    next_serial_receiver_if rxif ();

    next_serial_receiver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sin   (sin),
        .rx    (rxif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // tail: 0 drive sin=0 after last bit, 1 drive sin=1, 2 return before the last edge.
    // ready_last: raise out_ready together with the last payload bit.
    task automatic send_pkt(input logic [DATA_W-1:0] p, input int tail, input bit ready_last);
        @(negedge clk);
        sin = 1'b1;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            @(negedge clk);
            sin = p[i];
            if (i == 0 && ready_last) rxif.out_ready = 1'b1;
        end
        if (tail != 2) begin
            @(negedge clk);
            sin = (tail == 1);
        end
    endtask

    // Monitor: transfer and pulse sampling between edges.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (rxif.audio_req)      n_req++;
            if (rxif.audio_underrun) n_und++;
            if (rxif.data_loss)      n_loss++;
            if (rxif.frame_error)    n_ferr++;
            if (rxif.out_valid && rxif.out_ready) begin
                check("xfer_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check("xfer_data", 64'(rxif.out_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        sin   = 1'b0;
        rxif.out_ready = 1'b0;
        #3;
        check("rst_valid", 64'(rxif.out_valid), 64'd0);
        check("rst_data", 64'(rxif.out_data), 64'd0);
        check("rst_req", 64'(rxif.audio_req), 64'd0);
        check("rst_und", 64'(rxif.audio_underrun), 64'd0);
        check("rst_loss", 64'(rxif.data_loss), 64'd0);
        check("rst_ferr", 64'(rxif.frame_error), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single data packet, consumer ready.
        rxif.out_ready = 1'b1;
        exp_q.push_back(40'hDE_ADBE_EF01);
        send_pkt(40'hDE_ADBE_EF01, 0, 1'b0);
        check("t1_valid", 64'(rxif.out_valid), 64'd1);
        check("t1_data", 64'(rxif.out_data), 64'hDE_ADBE_EF01);
        @(negedge clk);
        check("t1_valid_fall", 64'(rxif.out_valid), 64'd0);

        // Audio control packets.
        send_pkt(PKT_AUDIO_REQ, 0, 1'b0);
        check("t2_req", 64'(rxif.audio_req), 64'd1);
        check("t2_valid", 64'(rxif.out_valid), 64'd0);
        @(negedge clk);
        check("t2_req_fall", 64'(rxif.audio_req), 64'd0);
        repeat (9) @(negedge clk);
        send_pkt(PKT_AUDIO_UNDERRUN, 0, 1'b0);
        check("t2_und", 64'(rxif.audio_underrun), 64'd1);
        check("t2_req_quiet", 64'(rxif.audio_req), 64'd0);
        check("t2_valid2", 64'(rxif.out_valid), 64'd0);
        @(negedge clk);
        check("t2_und_fall", 64'(rxif.audio_underrun), 64'd0);

        // Back-pressure: second packet dropped.
        rxif.out_ready = 1'b0;
        exp_q.push_back(40'h11_1111_1111);
        send_pkt(40'h11_1111_1111, 0, 1'b0);
        check("t3_valid", 64'(rxif.out_valid), 64'd1);
        send_pkt(40'h22_2222_2222, 0, 1'b0);
        check("t3_loss", 64'(rxif.data_loss), 64'd1);
        check("t3_hold", 64'(rxif.out_data), 64'h11_1111_1111);
        @(negedge clk);
        check("t3_loss_fall", 64'(rxif.data_loss), 64'd0);
        check("t3_hold2", 64'(rxif.out_data), 64'h11_1111_1111);
        rxif.out_ready = 1'b1;
        @(negedge clk);
        check("t3_drained", 64'(rxif.out_valid), 64'd0);

        // Drain and load on the same completing edge.
        rxif.out_ready = 1'b0;
        exp_q.push_back(40'h12_3456_7890);
        send_pkt(40'h12_3456_7890, 0, 1'b0);
        exp_q.push_back(40'h33_3333_3333);
        send_pkt(40'h33_3333_3333, 0, 1'b1);
        check("t4_valid", 64'(rxif.out_valid), 64'd1);
        check("t4_data", 64'(rxif.out_data), 64'h33_3333_3333);
        check("t4_noloss", 64'(rxif.data_loss), 64'd0);
        @(negedge clk);
        check("t4_valid_fall", 64'(rxif.out_valid), 64'd0);

        // Reset in the middle of a packet.
        @(negedge clk);
        sin = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sin = 1'($urandom_range(0, 1));
        end
        rst_n = 1'b0;
        sin   = 1'b0;
        #1;
        check("t5_rst_valid", 64'(rxif.out_valid), 64'd0);
        check("t5_rst_data", 64'(rxif.out_data), 64'd0);
        check("t5_rst_pulses", 64'({rxif.audio_req, rxif.audio_underrun,
                                    rxif.data_loss, rxif.frame_error}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back(40'hA5_A5A5_A5A5);
        send_pkt(40'hA5_A5A5_A5A5, 0, 1'b0);
        check("t5_data", 64'(rxif.out_data), 64'hA5_A5A5_A5A5);
        check("t5_valid", 64'(rxif.out_valid), 64'd1);
        repeat (3) @(negedge clk);

`ifdef RX_FRAME_CHECK_EN
        // High bit right after the packet: frame error, start suppressed.
        exp_q.push_back(40'h5A_5A5A_5A5A);
        send_pkt(40'h5A_5A5A_5A5A, 1, 1'b0);
        check("t6_data", 64'(rxif.out_data), 64'h5A_5A5A_5A5A);
        @(negedge clk);
        sin = 1'b0;
        check("t6_ferr", 64'(rxif.frame_error), 64'd1);
        @(negedge clk);
        check("t6_ferr_fall", 64'(rxif.frame_error), 64'd0);
        repeat (3) @(negedge clk);
        exp_q.push_back(40'hC3_C3C3_C3C3);
        send_pkt(40'hC3_C3C3_C3C3, 0, 1'b0);
        check("t6_resync_data", 64'(rxif.out_data), 64'hC3_C3C3_C3C3);
        check("t6_resync_valid", 64'(rxif.out_valid), 64'd1);
`else
        // Back-to-back packets with no gap.
        exp_q.push_back(40'h5A_5A5A_5A5A);
        exp_q.push_back(40'hC3_C3C3_C3C3);
        send_pkt(40'h5A_5A5A_5A5A, 2, 1'b0);
        send_pkt(40'hC3_C3C3_C3C3, 0, 1'b0);
        check("t6_b2b_data", 64'(rxif.out_data), 64'hC3_C3C3_C3C3);
        check("t6_b2b_valid", 64'(rxif.out_valid), 64'd1);
        check("t6_no_ferr", 64'(rxif.frame_error), 64'd0);
`endif

        repeat (60) @(negedge clk);
        check("end_queue_empty", 64'(exp_q.size()), 64'd0);
        check("end_req_count", 64'(n_req), 64'd1);
        check("end_und_count", 64'(n_und), 64'd1);
        check("end_loss_count", 64'(n_loss), 64'd1);
`ifdef RX_FRAME_CHECK_EN
        check("end_ferr_count", 64'(n_ferr), 64'd1);
`else
        check("end_ferr_count", 64'(n_ferr), 64'd0);
`endif
        check("end_valid", 64'(rxif.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
